regs_access_ctrl: RTL and testbench

- Initiator side of the register file interface: issues the two read ports and the single write port, and sits between decode, writeback and `regs`.
- Keeps a per-register scoreboard of outstanding writes and stalls decode on read-after-write hazards.
- Bypasses same-cycle writeback data into operand reads.
- Presents operands to execute through a registered valid/ready stage.

---
 rtl/regs_access_ctrl.sv | 107 ++++++++++
 tb/tb_regs_access_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regs_access_ctrl.sv
// Register-file access controller: scoreboards outstanding writes, stalls decode on
// hazards, bypasses same-cycle writeback data and registers operands for execute.
module regs_access_ctrl #(
  parameter int PENDING_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_rd_we_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [31:0] op_rs1_data_o,
  output logic [31:0] op_rs2_data_o,
  output logic [4:0]  op_rd_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic [4:0]  regs_raddr1_o,
  input  logic [31:0] regs_rdata1_i,
  output logic [4:0]  regs_raddr2_o,
  input  logic [31:0] regs_rdata2_i,
  output logic        regs_write_o,
  output logic [4:0]  regs_waddr_o,
  output logic [31:0] regs_wdata_o
);

  localparam logic [PENDING_W-1:0] CNT_MAX = '1;
  localparam logic [PENDING_W-1:0] CNT_ONE = PENDING_W'(1);

  logic [PENDING_W-1:0] r_cnt [32];
  logic                 r_op_valid;
  logic [31:0]          r_op_rs1_data;
  logic [31:0]          r_op_rs2_data;
  logic [4:0]           r_op_rd;

  logic        w_byp1, w_byp2;
  logic        w_src_stall1, w_src_stall2, w_dst_stall, w_hazard;
  logic        w_ready, w_accept, w_inc, w_dec;
  logic [31:0] w_rs1_data, w_rs2_data;

  assign regs_raddr1_o = dec_rs1_i;
  assign regs_raddr2_o = dec_rs2_i;
  assign regs_write_o  = wb_valid_i && (wb_rd_i != 5'd0);
  assign regs_waddr_o  = wb_rd_i;
  assign regs_wdata_o  = wb_data_i;

  // A source is only bypassable when the retiring write is the last one pending on it.
  assign w_byp1 = wb_valid_i && (wb_rd_i == dec_rs1_i) && (r_cnt[dec_rs1_i] == CNT_ONE);
  assign w_byp2 = wb_valid_i && (wb_rd_i == dec_rs2_i) && (r_cnt[dec_rs2_i] == CNT_ONE);

  assign w_src_stall1 = (dec_rs1_i != 5'd0) && (r_cnt[dec_rs1_i] != '0) && !w_byp1;
  assign w_src_stall2 = (dec_rs2_i != 5'd0) && (r_cnt[dec_rs2_i] != '0) && !w_byp2;
  assign w_dst_stall  = dec_rd_we_i && (dec_rd_i != 5'd0) && (r_cnt[dec_rd_i] == CNT_MAX);
  assign w_hazard     = w_src_stall1 || w_src_stall2 || w_dst_stall;

  assign w_ready  = !w_hazard && (!r_op_valid || op_ready_i);
  assign w_accept = dec_valid_i && w_ready;
  assign w_inc    = w_accept && dec_rd_we_i && (dec_rd_i != 5'd0);
  assign w_dec    = regs_write_o;

  assign w_rs1_data = (dec_rs1_i == 5'd0) ? 32'd0 : (w_byp1 ? wb_data_i : regs_rdata1_i);
  assign w_rs2_data = (dec_rs2_i == 5'd0) ? 32'd0 : (w_byp2 ? wb_data_i : regs_rdata2_i);

  assign dec_ready_o   = w_ready;
  assign op_valid_o    = r_op_valid;
  assign op_rs1_data_o = r_op_rs1_data;
  assign op_rs2_data_o = r_op_rs2_data;
  assign op_rd_o       = r_op_rd;

  // NOTE: the scoreboard must be cleared on reset (unlike a data RAM): stale counts
  // would stall decode forever; sequential state always uses non-blocking assignment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc && (dec_rd_i == 5'(i)) && !(w_dec && (wb_rd_i == 5'(i)))) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec && (wb_rd_i == 5'(i)) && !(w_inc && (dec_rd_i == 5'(i)))
                     && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_valid    <= 1'b0;
      r_op_rs1_data <= 32'd0;
      r_op_rs2_data <= 32'd0;
      r_op_rd       <= 5'd0;
    end else if (w_accept) begin
      r_op_valid    <= 1'b1;
      r_op_rs1_data <= w_rs1_data;
      r_op_rs2_data <= w_rs2_data;
      r_op_rd       <= dec_rd_we_i ? dec_rd_i : 5'd0;
    end else if (op_ready_i && r_op_valid) begin
      r_op_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regs_access_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a pending-write
// count model of the register access controller.
module tb_regs_access_ctrl;

  localparam int PW      = 2;
  localparam int MAX_CNT = (1 << PW) - 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i, dec_ready_o;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic        dec_rd_we_i;
  logic        op_valid_o, op_ready_i;
  logic [31:0] op_rs1_data_o, op_rs2_data_o;
  logic [4:0]  op_rd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [4:0]  regs_raddr1_o, regs_raddr2_o, regs_waddr_o;
  logic [31:0] regs_rdata1_i, regs_rdata2_i, regs_wdata_o;
  logic        regs_write_o;

  regs_access_ctrl #(.PENDING_W(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_rs1_data_o(op_rs1_data_o), .op_rs2_data_o(op_rs2_data_o), .op_rd_o(op_rd_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .regs_raddr1_o(regs_raddr1_o), .regs_rdata1_i(regs_rdata1_i),
    .regs_raddr2_o(regs_raddr2_o), .regs_rdata2_i(regs_rdata2_i),
    .regs_write_o(regs_write_o), .regs_waddr_o(regs_waddr_o), .regs_wdata_o(regs_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding write count per register and the operand stage.
  int          m_cnt [32];
  bit          m_valid;
  logic [31:0] m_d1, m_d2;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_valid = 1'b0;
    m_d1 = '0;
    m_d2 = '0;
    m_rd = '0;
  endtask

  // One clock cycle: drive inputs, check against model mid-cycle, then advance the model.
  task automatic step(input bit rst, input bit dv, input int rs1, input int rs2, input int rd,
                      input bit we, input bit ordy, input bit wbv, input int wbrd,
                      input logic [31:0] wbd, input logic [31:0] rd1, input logic [31:0] rd2);
    bit byp1, byp2, stall, ready, acc;
    logic [31:0] v1, v2;
    rst_i = rst; dec_valid_i = dv; dec_rs1_i = 5'(rs1); dec_rs2_i = 5'(rs2);
    dec_rd_i = 5'(rd); dec_rd_we_i = we; op_ready_i = ordy; wb_valid_i = wbv;
    wb_rd_i = 5'(wbrd); wb_data_i = wbd; regs_rdata1_i = rd1; regs_rdata2_i = rd2;
    #4;
    byp1  = wbv && wbrd == rs1 && m_cnt[rs1] == 1;
    byp2  = wbv && wbrd == rs2 && m_cnt[rs2] == 1;
    stall = (rs1 != 0 && m_cnt[rs1] > 0 && !byp1) || (rs2 != 0 && m_cnt[rs2] > 0 && !byp2)
            || (we && rd != 0 && m_cnt[rd] >= MAX_CNT);
    ready = !stall && (!m_valid || ordy);
    acc   = dv && ready;
    check("dec_ready", 32'(dec_ready_o), 32'(ready));
    check("raddr1", 32'(regs_raddr1_o), 32'(rs1));
    check("raddr2", 32'(regs_raddr2_o), 32'(rs2));
    check("regs_write", 32'(regs_write_o), 32'(wbv && wbrd != 0));
    if (wbv) begin
      check("waddr", 32'(regs_waddr_o), 32'(wbrd));
      check("wdata", regs_wdata_o, wbd);
    end
    check("op_valid", 32'(op_valid_o), 32'(m_valid));
    check("op_rs1", op_rs1_data_o, m_d1);
    check("op_rs2", op_rs2_data_o, m_d2);
    check("op_rd", 32'(op_rd_o), 32'(m_rd));
    v1 = (rs1 == 0) ? 32'd0 : (byp1 ? wbd : rd1);
    v2 = (rs2 == 0) ? 32'd0 : (byp2 ? wbd : rd2);
    @(posedge clk_i);
    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_d1 = v1; m_d2 = v2; m_rd = we ? 5'(rd) : 5'd0;
      end else if (ordy && m_valid) begin
        m_valid = 1'b0;
      end
      if (acc && we && rd != 0) m_cnt[rd] = m_cnt[rd] + 1;
      if (wbv && wbrd != 0 && m_cnt[wbrd] > 0) m_cnt[wbrd] = m_cnt[wbrd] - 1;
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 0, 0, 0, ordy, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(posedge clk_i); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // Basic read after reset, no destination write.
    step(0, 1, 1, 2, 4, 0, 1, 0, 0, 32'h0, 32'h11, 32'h22);
    idle(1);

    // RAW stall on rd=5, then bypass from writeback.
    step(0, 1, 0, 0, 5, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 1, 5, 0, 0, 0, 1, 0, 0, 32'h0, 32'h55, 32'h0);
    step(0, 1, 5, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 32'h55, 32'h0);
    idle(1);

    // x0: rd=0 never counted, rs1=0 reads zero, wb to x0 not written.
    step(0, 1, 0, 0, 0, 1, 1, 1, 0, 32'h1234, 32'hFFFF, 32'h0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'hAAAA, 32'h0);
    idle(1);

    // Saturation on rd=7, release by one writeback, reader stalls until count is one.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 7, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 7, 1, 1, 1, 7, 32'h70, 32'h0, 32'h0);
    step(0, 1, 0, 0, 7, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 1, 7, 0, 0, 0, 1, 1, 7, 32'h71, 32'h0, 32'h0);
    step(0, 1, 7, 0, 0, 0, 1, 1, 7, 32'h72, 32'h0, 32'h0);
    step(0, 1, 7, 0, 0, 0, 1, 1, 7, 32'h73, 32'h0, 32'h0);
    idle(1);

    // Backpressure for three cycles, then release with a new instruction.
    step(0, 1, 1, 2, 9, 1, 1, 0, 0, 32'h0, 32'hA1, 32'hA2);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 4, 0, 0, 0, 0, 0, 32'h0, 32'hB1, 32'hB2);
    step(0, 1, 3, 4, 0, 0, 1, 0, 0, 32'h0, 32'hC1, 32'hC2);
    step(0, 0, 0, 0, 0, 0, 1, 1, 9, 32'h99, 32'h0, 32'h0);

    // Reset mid-flight with two writes pending on x3.
    step(0, 1, 0, 0, 3, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 3, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 3, 32'h33, 32'h0, 32'h0);
    step(0, 1, 3, 0, 0, 0, 1, 0, 0, 32'h0, 32'h3333, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h34, 32'h0, 32'h0);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 5, $urandom_range(0, 7),
           $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
